conv_padding_sched: RTL and testbench
=====================================

// Module: conv_padding_sched
// PURPOSE
//  Layer-level sequencer for the conv padding engine. Splits one feature-map layer into row batches and drives one padding pass per batch.
//  Per batch: computes site_type/feature_row, waits for input buffer ready, pulses padding_start, waits padding_finish, releases the buffer.
//  Sits between the layer control regs (Lite) and the padding engine / line-buffer loader.
// PARAMETERS
//  MAX_BATCH_ROWS  16    upper clamp on rows per batch (<=128, feature_row is 7b)
//  TIMEOUT_CYCLES  2^20  watchdog limit in RUN, used only with CONV_PAD_SCHED_TIMEOUT_EN
// PORTS
//  sclk                 in   1  clock
//  s_rst_n              in   1  async reset, active-low
//  layer_start          in   1  1-cycle pulse; accepted only in IDLE
//  cfg_col_select       in   3  width code 0..5 (418/210/106/54/28/15 cols); latched at accept
//  cfg_feature_height   in   9  real input rows in layer, 1..416; latched at accept
//  cfg_batch_rows       in   7  real rows per batch, 1..MAX_BATCH_ROWS; latched at accept
//  buf_ready            in   1  level; input buffer holds the current batch
//  padding_finish       in   1  1-cycle pulse from padding engine
//  padding_start        out  1  1-cycle pulse to padding engine
//  site_type            out  2  0 first, 1 middle, 2 last, 3 first+last
//  feature_col_select   out  3  latched cfg_col_select, held for whole layer
//  feature_row          out  7  real rows in current batch minus 1
//  buf_release          out  1  1-cycle pulse, batch consumed
//  batch_idx            out  6  index of current batch, 0-based
//  busy                 out  1  high in any state except IDLE
//  layer_done           out  1  1-cycle pulse after last release
//  cfg_err              out  1  1-cycle pulse: rejected start
//  timeout_err          out  1  sticky; cleared by next accepted layer_start (macro only, else tied 0)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rows_left=0; first flag=1.
//  FSM: IDLE -> WAIT_BUF -> START -> RUN -> RELEASE -> (WAIT_BUF | DONE) -> IDLE.
//  IDLE: layer_start with height>=1 and batch_rows>=1: latch cfg, rows_left=height, first=1, batch_idx=0 -> WAIT_BUF next cycle.
//    Zero height or zero batch_rows: cfg_err=1 next cycle, stay IDLE. batch_rows > MAX_BATCH_ROWS: clamp to MAX_BATCH_ROWS.
//  WAIT_BUF: cur = min(rows_left, batch_rows); last = (rows_left <= batch_rows).
//    site_type = {last, first}: first&last=3, first=0, last=2, else 1. feature_row = cur-1.
//    Both registered on WAIT_BUF entry. buf_ready=1 -> START.
//  START: padding_start=1 for exactly this cycle -> RUN.
//  RUN: wait for padding_finish. A finish pulse in START or WAIT_BUF is ignored.
//  RELEASE: buf_release=1 for 1 cycle; rows_left -= cur; first=0.
//    rows_left==0 -> DONE, else batch_idx++ and -> WAIT_BUF.
//  DONE: layer_done=1 for 1 cycle -> IDLE.
//  site_type, feature_row: stable from START through RELEASE (engine reads them combinationally).
//  feature_col_select: stable from accept until the next accept.
//  layer_start while busy: ignored, no error.
//  Minimum turnaround with buf_ready held high: padding_finish -> next padding_start = 3 cycles.
//  Async reset mid-layer: immediate return to IDLE, outputs 0, no layer_done.
// CONFIGURATION
//  `CONV_PAD_SCHED_TIMEOUT_EN defined:
//    20b counter runs in RUN, cleared on RUN entry.
//    Reaching TIMEOUT_CYCLES: timeout_err=1 (sticky), FSM -> IDLE with no buf_release and no layer_done.
//  Undefined: no counter; timeout_err tied 0; RUN waits indefinitely.
// STRUCTURE
//  conv_pad_pkg: site-type localparams, FSM state encoding, column-width table (418..15).
//  Sub-module conv_pad_batch_calc (combinational): rows_left, batch_rows, first -> cur, last, site_type, feature_row.
//  FSM, counters and watchdog stay in this module.
// TESTING
//  height=52, batch=16, buf_ready=1: 4 batches; site 0,1,1,2; feature_row 15,15,15,3; one layer_done after 4th release.
//  height=13, batch=16: single batch, site_type=3, feature_row=12, batch_idx=0.
//  height=0: cfg_err pulse 1 cycle later; busy stays 0; no padding_start.
//  buf_ready low 50 cycles in WAIT_BUF: padding_start exactly 1 cycle after buf_ready rises; no early start.
//  s_rst_n low during RUN of batch 2: all outputs 0 at once; new layer_start after release runs from batch_idx 0.
//  With macro, TIMEOUT_CYCLES=100, no padding_finish: timeout_err=1 at cycle 100 of RUN; FSM IDLE; no buf_release.

Source files
------------

// File: rtl/conv_pad_pkg.sv
// Shared definitions for the conv padding scheduler: site-type codes,
// FSM state encoding and the column-width table for cfg_col_select codes.
package conv_pad_pkg;

    localparam logic [1:0] SITE_FIRST  = 2'd0;
    localparam logic [1:0] SITE_MIDDLE = 2'd1;
    localparam logic [1:0] SITE_LAST   = 2'd2;
    localparam logic [1:0] SITE_SINGLE = 2'd3;

    localparam int unsigned NUM_COL_CODES = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BUF = 3'd1,
        ST_START    = 3'd2,
        ST_RUN      = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_DONE     = 3'd5
    } sched_state_t;

    // Padded column count for each width code; unknown codes map to 0.
    function automatic logic [8:0] col_width(input logic [2:0] code);
        case (code)
            3'd0:    col_width = 9'd418;
            3'd1:    col_width = 9'd210;
            3'd2:    col_width = 9'd106;
            3'd3:    col_width = 9'd54;
            3'd4:    col_width = 9'd28;
            3'd5:    col_width = 9'd15;
            default: col_width = 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/conv_pad_batch_calc.sv
// Combinational batch geometry: rows in this batch, last-batch flag,
// site type and feature_row (rows-1) from remaining rows and batch size.
module conv_pad_batch_calc
    import conv_pad_pkg::*;
(
    input  logic [8:0] rows_left,
    input  logic [7:0] batch_rows,
    input  logic       first,
    output logic [7:0] cur,
    output logic       last,
    output logic [1:0] site_type,
    output logic [6:0] feature_row
);

    always_comb begin
        last        = (rows_left <= {1'b0, batch_rows});
        // When last, rows_left <= batch_rows so the top bit is zero.
        cur         = last ? rows_left[7:0] : batch_rows;
        feature_row = 7'(cur - 8'd1);
        case ({last, first})
            2'b11:   site_type = SITE_SINGLE;
            2'b01:   site_type = SITE_FIRST;
            2'b10:   site_type = SITE_LAST;
            default: site_type = SITE_MIDDLE;
        endcase
    end

endmodule

// File: rtl/conv_padding_sched.sv
// Layer-level sequencer: splits a layer into row batches and runs one padding
// pass per batch. Optional RUN watchdog enabled by CONV_PAD_SCHED_TIMEOUT_EN.
module conv_padding_sched
    import conv_pad_pkg::*;
#(
    parameter int unsigned MAX_BATCH_ROWS = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       layer_start,
    input  logic [2:0] cfg_col_select,
    input  logic [8:0] cfg_feature_height,
    input  logic [6:0] cfg_batch_rows,
    input  logic       buf_ready,
    input  logic       padding_finish,
    output logic       padding_start,
    output logic [1:0] site_type,
    output logic [2:0] feature_col_select,
    output logic [6:0] feature_row,
    output logic       buf_release,
    output logic [5:0] batch_idx,
    output logic       busy,
    output logic       layer_done,
    output logic       cfg_err,
    output logic       timeout_err
);

    localparam logic [7:0] MAX_BR = 8'(MAX_BATCH_ROWS);

    if (MAX_BATCH_ROWS < 1 || MAX_BATCH_ROWS > 128 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_params
        $error("conv_padding_sched: parameter out of range");
    end

    sched_state_t state, state_nxt;

    logic [8:0] rows_left_r;
    logic [7:0] batch_rows_r;
    logic       first_r;
    logic [7:0] cur_r;
    logic       last_r;

    logic       cfg_ok;
    logic       accept;
    logic       reject;
    logic [7:0] batch_clamped;
    logic [8:0] rows_after;
    logic       enter_wait;
    logic       timeout_hit;

    logic [8:0] calc_rows;
    logic [7:0] calc_batch;
    logic       calc_first;
    logic [7:0] calc_cur;
    logic       calc_last;
    logic [1:0] calc_site;
    logic [6:0] calc_frow;

    assign cfg_ok        = (cfg_feature_height != 9'd0) && (cfg_batch_rows != 7'd0);
    assign accept        = (state == ST_IDLE) && layer_start && cfg_ok;
    assign reject        = (state == ST_IDLE) && layer_start && !cfg_ok;
    assign batch_clamped = ({1'b0, cfg_batch_rows} > MAX_BR) ? MAX_BR : {1'b0, cfg_batch_rows};
    assign rows_after    = rows_left_r - {1'b0, cur_r};
    assign enter_wait    = (state_nxt == ST_WAIT_BUF) && (state != ST_WAIT_BUF);

    // Geometry is evaluated for the batch about to be entered: fresh config in
    // IDLE, or the post-release remainder in RELEASE.
    always_comb begin
        calc_rows  = rows_left_r;
        calc_batch = batch_rows_r;
        calc_first = first_r;
        if (state == ST_IDLE) begin
            calc_rows  = cfg_feature_height;
            calc_batch = batch_clamped;
            calc_first = 1'b1;
        end else if (state == ST_RELEASE) begin
            calc_rows  = rows_after;
            calc_first = 1'b0;
        end
    end

    conv_pad_batch_calc u_batch_calc (
        .rows_left   (calc_rows),
        .batch_rows  (calc_batch),
        .first       (calc_first),
        .cur         (calc_cur),
        .last        (calc_last),
        .site_type   (calc_site),
        .feature_row (calc_frow)
    );

`ifdef CONV_PAD_SCHED_TIMEOUT_EN
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic [19:0] to_cnt_r;
    logic        timeout_err_r;

    assign timeout_hit = (state == ST_RUN) && !padding_finish && (to_cnt_r == TO_LAST);
    assign timeout_err = timeout_err_r;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            to_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state == ST_START) begin
                to_cnt_r <= '0;
            end else if (state == ST_RUN) begin
                to_cnt_r <= to_cnt_r + 20'd1;
            end
            if (accept) begin
                timeout_err_r <= 1'b0;
            end else if (timeout_hit) begin
                timeout_err_r <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept) state_nxt = ST_WAIT_BUF;
            ST_WAIT_BUF: if (buf_ready) state_nxt = ST_START;
            ST_START:    state_nxt = ST_RUN;
            ST_RUN: begin
                if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end else if (padding_finish) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE:  state_nxt = last_r ? ST_DONE : ST_WAIT_BUF;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign padding_start = (state == ST_START);
    assign buf_release   = (state == ST_RELEASE);
    assign layer_done    = (state == ST_DONE);
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rows_left_r        <= '0;
            batch_rows_r       <= '0;
            first_r            <= 1'b1;
            cur_r              <= '0;
            last_r             <= 1'b0;
            site_type          <= '0;
            feature_row        <= '0;
            feature_col_select <= '0;
            batch_idx          <= '0;
            cfg_err            <= 1'b0;
        end else begin
            cfg_err <= reject;
            if (accept) begin
                feature_col_select <= cfg_col_select;
                rows_left_r        <= cfg_feature_height;
                batch_rows_r       <= batch_clamped;
                first_r            <= 1'b1;
                batch_idx          <= '0;
            end
            if (state == ST_RELEASE) begin
                rows_left_r <= rows_after;
                first_r     <= 1'b0;
                if (!last_r) begin
                    batch_idx <= batch_idx + 6'd1;
                end
            end
            // Engine reads these combinationally; they only change on WAIT_BUF entry.
            if (enter_wait) begin
                site_type   <= calc_site;
                feature_row <= calc_frow;
                cur_r       <= calc_cur;
                last_r      <= calc_last;
            end
        end
    end

endmodule

// File: tb/tb_conv_padding_sched.sv
// Bench for conv_padding_sched: scoreboard of expected per-batch geometry,
// a small padding-engine responder, and scenario tasks run in sequence.
module tb_conv_padding_sched;

    logic       sclk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       layer_start = 1'b0;
    logic [2:0] cfg_col_select = '0;
    logic [8:0] cfg_feature_height = '0;
    logic [6:0] cfg_batch_rows = '0;
    logic       buf_ready = 1'b0;
    logic       padding_finish = 1'b0;
    logic       padding_start;
    logic [1:0] site_type;
    logic [2:0] feature_col_select;
    logic [6:0] feature_row;
    logic       buf_release;
    logic [5:0] batch_idx;
    logic       busy;
    logic       layer_done;
    logic       cfg_err;
    logic       timeout_err;

    conv_padding_sched #(
        .MAX_BATCH_ROWS (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .sclk               (sclk),
        .s_rst_n            (s_rst_n),
        .layer_start        (layer_start),
        .cfg_col_select     (cfg_col_select),
        .cfg_feature_height (cfg_feature_height),
        .cfg_batch_rows     (cfg_batch_rows),
        .buf_ready          (buf_ready),
        .padding_finish     (padding_finish),
        .padding_start      (padding_start),
        .site_type          (site_type),
        .feature_col_select (feature_col_select),
        .feature_row        (feature_row),
        .buf_release        (buf_release),
        .batch_idx          (batch_idx),
        .busy               (busy),
        .layer_done         (layer_done),
        .cfg_err            (cfg_err),
        .timeout_err        (timeout_err)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [1:0] site;
        logic [6:0] frow;
        logic [5:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   start_cycs[$];
    int   fin_cycs[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_start  = 0;
    int n_rel    = 0;
    int n_done   = 0;
    int n_cfgerr = 0;
    int rel_cyc  = 0;
    int done_cyc = 0;
    int fin_delay = 1;
    logic eng_en = 1'b1;
    logic [8:0] snap;

    always @(posedge sclk) cyc <= cyc + 1;

    // Scoreboard monitor: pops one expected entry per padding_start.
    always @(negedge sclk) begin
        if (s_rst_n) begin
            if (padding_start) begin
                exp_t e;
                n_start++;
                start_cycs.push_back(cyc);
                snap = {site_type, feature_row};
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected_start got site=%0d row=%0d idx=%0d, expected no start",
                             site_type, feature_row, batch_idx);
                end else begin
                    e = exp_q.pop_front();
                    if ({site_type, feature_row, batch_idx} !== e)
                        $display("FAIL sb_batch got site=%0d row=%0d idx=%0d, expected site=%0d row=%0d idx=%0d",
                                 site_type, feature_row, batch_idx, e.site, e.frow, e.idx);
                    else
                        n_pass++;
                end
            end
            if (padding_finish && busy) fin_cycs.push_back(cyc);
            if (buf_release) begin
                n_rel++;
                rel_cyc = cyc;
                n_checks++;
                if ({site_type, feature_row} !== snap)
                    $display("FAIL geom_stable got %0h, expected %0h", {site_type, feature_row}, snap);
                else
                    n_pass++;
            end
            if (layer_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (cfg_err) n_cfgerr++;
        end
    end

    // Padding engine model: answers each start with a finish pulse.
    initial begin
        forever begin
            @(negedge sclk);
            if (padding_start && eng_en && s_rst_n) begin
                repeat (fin_delay) @(posedge sclk);
                #1 padding_finish = 1'b1;
                @(posedge sclk);
                #1 padding_finish = 1'b0;
            end
        end
    end

    task automatic clear_counts();
        n_start = 0; n_rel = 0; n_done = 0; n_cfgerr = 0;
        start_cycs.delete();
        fin_cycs.delete();
    endtask

    task automatic start_layer(input int h, input int b, input int col);
        @(posedge sclk);
        #1;
        cfg_feature_height = 9'(h);
        cfg_batch_rows     = 7'(b);
        cfg_col_select     = 3'(col);
        layer_start        = 1'b1;
        @(posedge sclk);
        #1 layer_start = 1'b0;
    endtask

    task automatic push_exp(input int site, input int frow, input int idx);
        exp_t e;
        e.site = 2'(site);
        e.frow = 7'(frow);
        e.idx  = 6'(idx);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        n_checks++;
        if ({padding_start, site_type, feature_col_select, feature_row, buf_release,
             batch_idx, busy, layer_done, cfg_err, timeout_err} !== 24'd0)
            $display("FAIL reset_outputs got %0h, expected 0",
                     {padding_start, site_type, feature_col_select, feature_row, buf_release,
                      batch_idx, busy, layer_done, cfg_err, timeout_err});
        else n_pass++;
        s_rst_n = 1'b1;
        repeat (2) @(negedge sclk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy=%0b, expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_four_batches();
        clear_counts();
        buf_ready = 1'b1; eng_en = 1'b1; fin_delay = 1;
        push_exp(0, 15, 0); push_exp(1, 15, 1); push_exp(1, 15, 2); push_exp(2, 3, 3);
        start_layer(52, 16, 2);
        repeat (6) @(negedge sclk);
        start_layer(0, 16, 5);
        for (int i = 0; i < 300; i++) begin
            if (n_done != 0) break;
            @(negedge sclk);
        end
        repeat (3) @(negedge sclk);
        n_checks++;
        if (n_done !== 1) $display("FAIL four_done got %0d, expected 1", n_done); else n_pass++;
        n_checks++;
        if (n_start !== 4 || n_rel !== 4)
            $display("FAIL four_counts starts=%0d releases=%0d, expected 4/4", n_start, n_rel);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL four_sb_left got %0d, expected 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (feature_col_select !== 3'd2) $display("FAIL four_colsel got %0d, expected 2", feature_col_select);
        else n_pass++;
        n_checks++;
        if (n_cfgerr !== 0) $display("FAIL busy_start_err got %0d, expected 0", n_cfgerr); else n_pass++;
        n_checks++;
        if (done_cyc - rel_cyc !== 1) $display("FAIL done_after_rel got %0d, expected 1", done_cyc - rel_cyc);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (start_cycs.size() < i + 2 || fin_cycs.size() < i + 1)
                $display("FAIL turnaround_%0d missing events, expected 3 cycles", i);
            else if (start_cycs[i+1] - fin_cycs[i] !== 3)
                $display("FAIL turnaround_%0d got %0d, expected 3", i, start_cycs[i+1] - fin_cycs[i]);
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL four_idle busy=%0b, expected 0", busy); else n_pass++;
    endtask

    task automatic test_single_and_clamp();
        int hs[3]  = '{13, 16, 20};
        int bs[3]  = '{16, 16, 100};
        int nb[3]  = '{1, 1, 2};
        buf_ready = 1'b1; eng_en = 1'b1; fin_delay = 2;
        push_exp(3, 12, 0);
        push_exp(3, 15, 0);
        push_exp(0, 15, 0); push_exp(2, 3, 1);
        for (int k = 0; k < 3; k++) begin
            clear_counts();
            start_layer(hs[k], bs[k], k);
            for (int i = 0; i < 200; i++) begin
                if (n_done != 0) break;
                @(negedge sclk);
            end
            @(negedge sclk);
            n_checks++;
            if (n_done !== 1 || n_start !== nb[k])
                $display("FAIL layer_%0d done=%0d starts=%0d, expected 1/%0d", k, n_done, n_start, nb[k]);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL single_sb_left got %0d, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_cfg_err();
        int hs[2] = '{0, 5};
        int bs[2] = '{5, 0};
        clear_counts();
        for (int k = 0; k < 2; k++) begin
            start_layer(hs[k], bs[k], 1);
            @(negedge sclk);
            n_checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0)
                $display("FAIL cfg_err_%0d err=%0b busy=%0b, expected 1/0", k, cfg_err, busy);
            else n_pass++;
            @(negedge sclk);
            n_checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0)
                $display("FAIL cfg_err_pulse_%0d err=%0b busy=%0b, expected 0/0", k, cfg_err, busy);
            else n_pass++;
        end
        repeat (4) @(negedge sclk);
        n_checks++;
        if (n_start !== 0) $display("FAIL cfg_err_start got %0d, expected 0", n_start); else n_pass++;
    endtask

    task automatic test_buf_wait();
        clear_counts();
        buf_ready = 1'b0; eng_en = 1'b1; fin_delay = 1;
        push_exp(3, 4, 0);
        start_layer(5, 8, 4);
        repeat (50) @(negedge sclk);
        n_checks++;
        if (n_start !== 0 || busy !== 1'b1)
            $display("FAIL buf_wait starts=%0d busy=%0b, expected 0/1", n_start, busy);
        else n_pass++;
        @(posedge sclk);
        #1 buf_ready = 1'b1;
        @(negedge sclk);
        n_checks++;
        if (padding_start !== 1'b0) $display("FAIL buf_early_start got %0b, expected 0", padding_start);
        else n_pass++;
        @(negedge sclk);
        n_checks++;
        if (padding_start !== 1'b1) $display("FAIL buf_start got %0b, expected 1", padding_start);
        else n_pass++;
        for (int i = 0; i < 100; i++) begin
            if (n_done != 0) break;
            @(negedge sclk);
        end
        n_checks++;
        if (n_done !== 1) $display("FAIL buf_done got %0d, expected 1", n_done); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_counts();
        buf_ready = 1'b1; eng_en = 1'b1; fin_delay = 8;
        push_exp(0, 15, 0); push_exp(1, 15, 1); push_exp(1, 15, 2); push_exp(2, 3, 3);
        start_layer(52, 16, 3);
        for (int i = 0; i < 200; i++) begin
            if (n_start >= 2) break;
            @(negedge sclk);
        end
        @(posedge sclk);
        #3;
        n_checks++;
        if (busy !== 1'b1 || batch_idx !== 6'd1)
            $display("FAIL mid_state busy=%0b idx=%0d, expected 1/1", busy, batch_idx);
        else n_pass++;
        s_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({padding_start, site_type, feature_col_select, feature_row, buf_release,
             batch_idx, busy, layer_done, cfg_err, timeout_err} !== 24'd0)
            $display("FAIL mid_reset_outputs got %0h, expected 0",
                     {padding_start, site_type, feature_col_select, feature_row, buf_release,
                      batch_idx, busy, layer_done, cfg_err, timeout_err});
        else n_pass++;
        repeat (12) @(negedge sclk);
        s_rst_n = 1'b1;
        exp_q.delete();
        n_checks++;
        if (n_done !== 0) $display("FAIL mid_no_done got %0d, expected 0", n_done); else n_pass++;
        clear_counts();
        fin_delay = 1;
        push_exp(3, 12, 0);
        start_layer(13, 16, 0);
        for (int i = 0; i < 100; i++) begin
            if (n_done != 0) break;
            @(negedge sclk);
        end
        n_checks++;
        if (n_done !== 1 || exp_q.size() !== 0)
            $display("FAIL mid_restart done=%0d left=%0d, expected 1/0", n_done, exp_q.size());
        else n_pass++;
    endtask

`ifdef CONV_PAD_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int s;
        int t;
        clear_counts();
        buf_ready = 1'b1; eng_en = 1'b0;
        push_exp(3, 4, 0);
        start_layer(5, 8, 1);
        for (int i = 0; i < 50; i++) begin
            if (n_start != 0) break;
            @(negedge sclk);
        end
        s = start_cycs.size() > 0 ? start_cycs[0] : 0;
        t = 0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                t = cyc;
                break;
            end
            @(negedge sclk);
        end
        n_checks++;
        if (t - s !== 101) $display("FAIL timeout_cycle got %0d, expected 101", t - s); else n_pass++;
        n_checks++;
        if (timeout_err !== 1'b1 || n_rel !== 0 || n_done !== 0)
            $display("FAIL timeout_flags err=%0b rel=%0d done=%0d, expected 1/0/0", timeout_err, n_rel, n_done);
        else n_pass++;
        eng_en = 1'b1; fin_delay = 1;
        push_exp(3, 4, 0);
        start_layer(5, 8, 1);
        @(negedge sclk);
        n_checks++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_clear got %0b, expected 0", timeout_err);
        else n_pass++;
        repeat (20) @(negedge sclk);
    endtask
`endif

    initial begin
        test_reset();
        test_four_batches();
        test_single_and_clamp();
        test_cfg_err();
        test_buf_wait();
        test_reset_mid();
`ifdef CONV_PAD_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
